// File: rtl/simt_mem_arbiter.sv
// rtl/simt_mem_arbiter.sv - round-robin N-channel memory arbiter with retry, timeout and halt aggregation
// Serialises NREQ load/store requesters onto one RAM port, one transfer per grant.

module simt_mem_arbiter #(
   parameter int NREQ    = 4,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic [NREQ-1:0]    req_ren,
   input  logic [NREQ-1:0]    req_wen,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_store,
   output logic [NREQ-1:0]    req_wait,
   output logic [NREQ-1:0]    req_err,
   output logic [DW-1:0]      req_load,
   input  logic [NREQ-1:0]    flushed,
   output logic               halt,
   output logic [AW-1:0]      ramaddr,
   output logic [DW-1:0]      ramstore,
   output logic               ramREN,
   output logic               ramWEN,
   input  logic [DW-1:0]      ramload,
   input  logic [1:0]         ramstate
);

   localparam int         GW        = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [7:0] TLIM      = (TIMEOUT > 0) ? 8'(TIMEOUT - 1) : 8'd0;
   localparam logic [1:0] RS_ACCESS = 2'd2;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state, state_nx;
   logic [GW-1:0]   rr_ptr, grant, pick, next_ptr;
   logic            pick_vld;
   logic            op_wr;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   store_q, load_q;
   logic [7:0]      timer;
   logic            halt_q;
   logic [NREQ-1:0] active, gmask, rel_mask;
   logic            done, tout, start, halt_set;

   assign active   = req_ren | req_wen;
   assign done     = (state == GRANT) && (ramstate == RS_ACCESS);
   assign tout     = (state == GRANT) && !done && (TIMEOUT != 0) && (timer == TLIM);
   assign halt_set = (state == IDLE) && (&flushed);
   // A halting system takes no new grants, including on the edge halt itself sets.
   assign start    = (state == IDLE) && pick_vld && !halt_q && !halt_set;
   assign next_ptr = (grant == GW'(NREQ - 1)) ? '0 : grant + 1'b1;

   assign ramaddr  = addr_q;
   assign ramstore = store_q;
   assign halt     = halt_q;
   assign req_wait = active & ~rel_mask;

   always_comb begin : rr_pick
      int idx;
      pick_vld = 1'b0;
      pick     = '0;
      idx      = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(rr_ptr) + k) % NREQ;
         if (!pick_vld && active[idx]) begin
            pick_vld = 1'b1;
            pick     = GW'(idx);
         end
      end
   end

   always_comb begin
      gmask        = '0;
      gmask[grant] = 1'b1;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      req_err  = '0;
      rel_mask = '0;
      req_load = load_q;
      case (state)
         IDLE: begin
            if (start) state_nx = GRANT;
         end
         GRANT: begin
            ramREN = !op_wr;
            ramWEN = op_wr;
            if (done || tout) begin
               rel_mask = gmask;
               state_nx = IDLE;
            end
            if (tout)           req_err  = gmask;
            if (done && !op_wr) req_load = ramload;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         rr_ptr  <= '0;
         grant   <= '0;
         op_wr   <= 1'b0;
         addr_q  <= '0;
         store_q <= '0;
         load_q  <= '0;
         timer   <= '0;
         halt_q  <= 1'b0;
      end else begin
         if (halt_set) halt_q <= 1'b1;
         if (start) begin
            grant   <= pick;
            op_wr   <= req_wen[pick];
            addr_q  <= req_addr[int'(pick)*AW +: AW];
            store_q <= req_store[int'(pick)*DW +: DW];
            timer   <= '0;
         end else if (state == GRANT) begin
            // ERROR, BUSY and FREE all hold the latched access and keep counting.
            if (done || tout) begin
               rr_ptr <= next_ptr;
               timer  <= '0;
               if (done && !op_wr) load_q <= ramload;
            end else begin
               timer <= timer + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_simt_mem_arbiter.sv
// tb/tb_simt_mem_arbiter.sv - scoreboard bench for simt_mem_arbiter
// Stimulus pushes expected completions; a negedge monitor pops and compares them.

module tb_simt_mem_arbiter;

   localparam logic [31:0] KEY = 32'hDEADBEAF;

   logic         clk, nrst;
   logic [3:0]   req_ren, req_wen, req_wait, req_err, flushed;
   logic [127:0] req_addr, req_store;
   logic [31:0]  req_load, ram_addr, ram_store, ram_load;
   logic         halt, ram_ren, ram_wen;
   logic [1:0]   ram_state;

   simt_mem_arbiter #(.NREQ(4), .AW(32), .DW(32), .TIMEOUT(8)) dut (
      .CLK(clk), .nRST(nrst),
      .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr), .req_store(req_store),
      .req_wait(req_wait), .req_err(req_err), .req_load(req_load),
      .flushed(flushed), .halt(halt),
      .ramaddr(ram_addr), .ramstore(ram_store), .ramREN(ram_ren), .ramWEN(ram_wen),
      .ramload(ram_load), .ramstate(ram_state)
   );

   typedef struct packed {
      logic [3:0]  mask;
      logic        err;
      logic        ren;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] data;
      logic [7:0]  cyc;
      logic        steady;
   } rec_t;

   rec_t q[$];
   rec_t obs, expv;
   int   checks = 0;
   int   errors = 0;
   int   ncomp  = 0;

   int          gcnt = 0;
   int          err_n = 0, busy_n = 0;
   logic [31:0] hang_addr = 32'hFFFF_FFFF;
   logic [31:0] f_addr, f_store;
   logic        f_ren, f_wen, steady;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // RAM model: err_n ERROR cycles, then busy_n BUSY cycles, then ACCESS; hang_addr never completes.
   initial begin
      ram_state = 2'd0;
      ram_load  = 32'h0;
      steady    = 1'b1;
   end

   always @(posedge clk) begin
      #1;
      if (ram_ren || ram_wen) begin
         if (gcnt == 0) begin
            f_addr = ram_addr; f_store = ram_store; f_ren = ram_ren; f_wen = ram_wen;
            steady = 1'b1;
         end else if (ram_addr !== f_addr || ram_store !== f_store || ram_ren !== f_ren || ram_wen !== f_wen) begin
            steady = 1'b0;
         end
         gcnt++;
         if (ram_addr == hang_addr)      ram_state = 2'd1;
         else if (gcnt <= err_n)         ram_state = 2'd3;
         else if (gcnt <= err_n + busy_n) ram_state = 2'd1;
         else                            ram_state = 2'd2;
         ram_load = ram_addr ^ KEY;
      end else begin
         gcnt      = 0;
         ram_state = 2'd0;
      end
   end

   always @(negedge clk) begin
      if (nrst && (ram_ren || ram_wen) && (ram_state == 2'd2 || req_err != 4'b0)) begin
         obs.mask   = (req_err != 4'b0) ? req_err : ((req_ren | req_wen) & ~req_wait);
         obs.err    = (req_err != 4'b0);
         obs.ren    = ram_ren;
         obs.wen    = ram_wen;
         obs.addr   = ram_addr;
         obs.data   = ram_wen ? ram_store : (obs.err ? 32'h0 : req_load);
         obs.cyc    = 8'(gcnt);
         obs.steady = steady;
         ncomp++;
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_completion: got mask=%b err=%b addr=%h, required no completion",
                     obs.mask, obs.err, obs.addr);
         end else begin
            expv = q.pop_front();
            if (obs !== expv) begin
               errors++;
               $display("FAIL completion: got mask=%b err=%b ren=%b wen=%b addr=%h data=%h cyc=%0d steady=%b, required mask=%b err=%b ren=%b wen=%b addr=%h data=%h cyc=%0d steady=%b",
                        obs.mask, obs.err, obs.ren, obs.wen, obs.addr, obs.data, obs.cyc, obs.steady,
                        expv.mask, expv.err, expv.ren, expv.wen, expv.addr, expv.data, expv.cyc, expv.steady);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_c(input logic [3:0] m, input logic e, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d, input int c);
      rec_t x;
      x.mask = m; x.err = e; x.ren = r; x.wen = w; x.addr = a; x.data = d;
      x.cyc = 8'(c); x.steady = 1'b1;
      q.push_back(x);
   endtask

   task automatic set_req(input int ch, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      req_ren[ch] = r;
      req_wen[ch] = w;
      req_addr[ch*32 +: 32]  = a;
      req_store[ch*32 +: 32] = d;
   endtask

   task automatic wait_release(input int ch);
      int n;
      n = 0;
      @(negedge clk);
      while (req_wait[ch] !== 1'b0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 40) begin
         errors++;
         $display("FAIL release_ch%0d: got req_wait still high after %0d cycles, required release", ch, n);
      end
      tick();
   endtask

   task automatic wait_comps(input int target);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (ncomp < target && n < 60);
      checks++;
      if (ncomp < target) begin
         errors++;
         $display("FAIL completions: got %0d, required %0d", ncomp, target);
      end
      tick();
   endtask

   task automatic do_reset();
      nrst = 1'b0;
      tick();
      tick();
      nrst = 1'b1;
   endtask

   initial begin
      nrst = 1'b0; req_ren = 4'b0100; req_wen = 4'b0; req_addr = '0; req_store = '0; flushed = 4'b0;

      // reset state, req_wait follows the live mask
      @(posedge clk); #1;
      chk("rst_halt", 32'(halt), 32'd0);
      chk("rst_ren_wen", {30'd0, ram_ren, ram_wen}, 32'd0);
      chk("rst_ramaddr", ram_addr, 32'd0);
      chk("rst_ramstore", ram_store, 32'd0);
      chk("rst_req_err", 32'(req_err), 32'd0);
      chk("rst_req_load", req_load, 32'd0);
      chk("rst_req_wait", 32'(req_wait), 32'b0100);
      req_ren = 4'b0;
      tick();
      nrst = 1'b1;
      tick();

      // single read on ch2, ACCESS on 2nd grant cycle
      busy_n = 1; err_n = 0;
      expect_c(4'b0100, 1'b0, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 2);
      set_req(2, 1'b1, 1'b0, 32'h40, 32'h0);
      wait_release(2);
      set_req(2, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      // round-robin from rr_ptr=0, all channels continuously active
      do_reset();
      busy_n = 0;
      for (int c = 0; c < 4; c++) expect_c(4'(1 << c), 1'b0, 1'b1, 1'b0, 32'h100 + 32'(4*c), (32'h100 + 32'(4*c)) ^ KEY, 1);
      expect_c(4'b0001, 1'b0, 1'b1, 1'b0, 32'h100, 32'h100 ^ KEY, 1);
      begin
         int target;
         target = ncomp + 5;
         for (int c = 0; c < 4; c++) set_req(c, 1'b1, 1'b0, 32'h100 + 32'(4*c), 32'h0);
         wait_comps(target);
      end
      req_ren = 4'b0;
      tick();

      // write priority and latching against a mid-grant address change
      busy_n = 3;
      expect_c(4'b0010, 1'b0, 1'b0, 1'b1, 32'h80, 32'h1234, 4);
      set_req(1, 1'b1, 1'b1, 32'h80, 32'h1234);
      tick();
      tick();
      set_req(1, 1'b1, 1'b1, 32'h90, 32'h5678);
      wait_release(1);
      set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();

      // three ERROR cycles then ACCESS on ch3
      busy_n = 0; err_n = 3;
      expect_c(4'b1000, 1'b0, 1'b1, 1'b0, 32'h200, 32'h200 ^ KEY, 4);
      set_req(3, 1'b1, 1'b0, 32'h200, 32'h0);
      wait_release(3);
      set_req(3, 1'b0, 1'b0, 32'h0, 32'h0);
      err_n = 0;
      tick();

      // timeout on ch0 in the 8th grant cycle, then ch2 is served
      hang_addr = 32'h300;
      expect_c(4'b0001, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 8);
      expect_c(4'b0100, 1'b0, 1'b1, 1'b0, 32'h340, 32'h340 ^ KEY, 1);
      set_req(0, 1'b1, 1'b0, 32'h300, 32'h0);
      set_req(2, 1'b1, 1'b0, 32'h340, 32'h0);
      wait_release(0);
      set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
      wait_release(2);
      set_req(2, 1'b0, 1'b0, 32'h0, 32'h0);
      hang_addr = 32'hFFFF_FFFF;
      tick();

      // halt waits for the in-flight access, then blocks new grants
      busy_n = 2;
      expect_c(4'b0010, 1'b0, 1'b1, 1'b0, 32'h400, 32'h400 ^ KEY, 3);
      set_req(1, 1'b1, 1'b0, 32'h400, 32'h0);
      tick();
      flushed = 4'hF;
      @(negedge clk);
      chk("halt_in_grant", 32'(halt), 32'd0);
      wait_release(1);
      set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
      set_req(0, 1'b1, 1'b0, 32'h440, 32'h0);
      chk("halt_pending", 32'(halt), 32'd0);
      tick();
      chk("halt_set", 32'(halt), 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("halt_no_grant", {30'd0, ram_ren, ram_wen}, 32'd0);
         chk("halt_wait_held", 32'(req_wait[0]), 32'd1);
      end
      tick();
      nrst = 1'b0;
      #1;
      chk("halt_reset", 32'(halt), 32'd0);
      set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
      flushed = 4'b0;
      tick();
      nrst = 1'b1;
      tick();

      // move rr_ptr to 2, then reset in the middle of a hung write on ch2
      busy_n = 0;
      expect_c(4'b0010, 1'b0, 1'b1, 1'b0, 32'h600, 32'h600 ^ KEY, 1);
      set_req(1, 1'b1, 1'b0, 32'h600, 32'h0);
      wait_release(1);
      set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
      hang_addr = 32'h500;
      set_req(2, 1'b0, 1'b1, 32'h500, 32'hCAFE);
      tick();
      tick();
      tick();
      @(negedge clk);
      chk("midgrant_wen", 32'(ram_wen), 32'd1);
      chk("midgrant_addr", ram_addr, 32'h500);
      nrst = 1'b0;
      #1;
      chk("areset_ren_wen", {30'd0, ram_ren, ram_wen}, 32'd0);
      chk("areset_halt", 32'(halt), 32'd0);
      chk("areset_wait", 32'(req_wait), 32'b0100);
      chk("areset_addr", ram_addr, 32'd0);
      tick();
      set_req(2, 1'b0, 1'b0, 32'h0, 32'h0);
      hang_addr = 32'hFFFF_FFFF;
      nrst = 1'b1;
      tick();

      // rr_ptr back at 0: ch1 before ch3
      expect_c(4'b0010, 1'b0, 1'b1, 1'b0, 32'h640, 32'h640 ^ KEY, 1);
      expect_c(4'b1000, 1'b0, 1'b1, 1'b0, 32'h6C0, 32'h6C0 ^ KEY, 1);
      set_req(1, 1'b1, 1'b0, 32'h640, 32'h0);
      set_req(3, 1'b1, 1'b0, 32'h6C0, 32'h0);
      wait_release(1);
      set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
      wait_release(3);
      set_req(3, 1'b0, 1'b0, 32'h0, 32'h0);

      repeat (5) tick();
      chk("sb_empty", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
